col_norm_calc: RTL
==================

Name: col_norm_calc

Overview:
- Sequential column squared-norm engine in the sorted-QR front end of the 4x4 MIMO detector.
- Sits directly upstream of the column permutation stage and feeds it a registered channel matrix, per-column norms and an identity column order.
- Accepts one real-valued 8x8 H matrix, accumulates one row per cycle, and presents results with a valid/ready handshake.

Parameters:
- WL, 16, element word length; signed, two's complement.
- FWL, 12, element fractional bits.
- COLNORM_WL, 7, norm word length; unsigned.
- COLNORM_FWL, 4, norm fractional bits. Requires 2*FWL >= COLNORM_FWL.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  input matrix valid.
- ready_o  out  1  block can accept a matrix.
- Hmatrix_i  in  WL*64  element h[i][j] at bits [8*WL*i + WL*j +: WL].
- valid_o  out  1  outputs valid.
- ready_i  in  1  downstream accepts outputs.
- Hmatrix_o  out  WL*64  captured matrix; same packing as Hmatrix_i.
- colnorm_o  out  COLNORM_WL*8  norm of column j at bits [COLNORM_WL*j +: COLNORM_WL].
- colorder_o  out  24  3-bit order field j at bits [3*j +: 3].

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; ready_o=1; valid_o=0.
  - Hmatrix_o=0, colnorm_o=0, colorder_o=0; row counter=0; accumulators=0.
- States: IDLE, ACC, OUT.
- IDLE:
  - ready_o=1.
  - On the edge where valid_i && ready_o: capture Hmatrix_i into the H register, clear all 8 accumulators, set row=0, go to ACC.
- ACC (ready_o=0, valid_o=0):
  - Each edge, acc[j] += h[row][j]^2 for all 8 columns in parallel (8 squarers).
  - Then row increments.
  - On the edge that processes row 7: register the norms and go to OUT.
  - Exactly 8 ACC cycles.
- OUT:
  - valid_o=1; outputs held stable while valid_o && !ready_i.
  - On the edge where ready_i=1: go to IDLE; valid_o drops.
  - No new input is accepted in the same cycle (no overlap); ready_o rises the cycle after.
- Latency: valid_o is high after the 9th rising edge counting the accept edge as edge 1. Throughput is one matrix per 10 cycles at minimum with ready_i tied high.
- Arithmetic:
  - Each square is 2*WL bits, unsigned, with 2*FWL fractional bits.
  - acc is 2*WL+3 bits, unsigned; it cannot overflow internally.
  - Norm = acc >> (2*FWL - COLNORM_FWL), truncated toward zero, then reduced to COLNORM_WL bits per the Optional Feature.
- Outputs:
  - colorder_o = identity: field j = j, written when entering OUT.
  - Hmatrix_o = captured H, unchanged.
- Boundary conditions:
  - valid_i while not in IDLE is ignored; the source must hold its data.
  - Reset mid-ACC or mid-OUT aborts immediately and forces all reset values.
  - h = -2^(WL-1) squares correctly as 2^(2WL-2), unsigned.

Optional Feature:
- Macro: COLNORM_SAT_EN.
- Defined: if any acc bit above the shifted COLNORM_WL-bit field is set, the norm saturates to 2^COLNORM_WL - 1 (127).
- Undefined: plain truncation to the low COLNORM_WL bits of the shifted accumulator (modular wrap). This saves the OR-reduce logic.

Test Plan:
1. Reset then idle: check ready_o=1, valid_o=0 and all outputs 0. Assert rst_n low mid-ACC: outputs return to 0 and state to IDLE, with no spurious valid_o.
2. Zero matrix, ready_i=1: valid_o rises 9 edges after accept; colnorm_o all 0; colorder_o=24'o76543210; Hmatrix_o=0.
3. Only h[3][5]=16'd4096 (1.0): column 5 norm=16; all others 0.
4. Column 0 = {-461,3579,-1300,-1779,-1269,3111,-2773,2237}, i.e. h[0..7][0] in row order, and column 1 = {-3579,-461,1779,-1300,-3111,-1269,-2237,-2773}, i.e. h[0..7][1] in row order:
   - Sum of squares = 41858983 for each.
   - Norm = floor(41858983/2^20) = 39 for both columns.
5. All elements = -16'sd32768:
   - acc = 2^33 and shifted value = 8192.
   - With COLNORM_SAT_EN, every norm = 127; without it, every norm = 0.
6. Stall: hold ready_i=0 for 5 cycles in OUT, then pulse valid_i. Required response:
   - Outputs stay stable and ready_o=0; valid_i is ignored.
   - After ready_i=1, one edge later valid_o=0 and ready_o=1.
   - A second matrix is then accepted and produces correct norms.

Source files
------------

// File: rtl/col_norm_calc.sv
// Column squared-norm engine: squares and accumulates one row of an 8x8 H per cycle and emits per-column norms.
// Define COLNORM_SAT_EN to saturate norms at full scale; otherwise the norm wraps to its low COLNORM_WL bits.
module col_norm_calc #(
  parameter int WL          = 16,
  parameter int FWL         = 12,
  parameter int COLNORM_WL  = 7,
  parameter int COLNORM_FWL = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [WL*64-1:0]          Hmatrix_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [WL*64-1:0]          Hmatrix_o,
  output logic [COLNORM_WL*8-1:0]   colnorm_o,
  output logic [23:0]               colorder_o
);

  localparam int ACC_WL = 2*WL + 3;
  localparam int SHIFT  = 2*FWL - COLNORM_FWL;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                    state_q, state_d;
  logic [WL*64-1:0]          h_q, h_d;
  logic [ACC_WL-1:0]         acc_q [8];
  logic [ACC_WL-1:0]         acc_d [8];
  logic [2:0]                row_q, row_d;
  logic [COLNORM_WL*8-1:0]   colnorm_q, colnorm_d;
  logic [23:0]               colorder_q, colorder_d;

  logic signed [2*WL-1:0]    elem_ext [8];
  logic signed [2*WL-1:0]    prod [8];
  logic [ACC_WL-1:0]         sum [8];
  logic [COLNORM_WL-1:0]     norm [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i)       state_d = ACC;
      ACC:     if (row_q == 3'd7) state_d = OUT;
      OUT:     if (ready_i)       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == OUT);
  end

  // Sign-extend before squaring so -2^(WL-1) yields the correct positive 2^(2WL-2).
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      elem_ext[j] = {{WL{h_q[8*WL*int'(row_q) + WL*j + WL-1]}},
                     h_q[8*WL*int'(row_q) + WL*j +: WL]};
      prod[j]     = elem_ext[j] * elem_ext[j];
      sum[j]      = acc_q[j] + ACC_WL'(unsigned'(prod[j]));
`ifdef COLNORM_SAT_EN
      norm[j]     = (|sum[j][ACC_WL-1:SHIFT+COLNORM_WL]) ? '1 : sum[j][SHIFT +: COLNORM_WL];
`else
      norm[j]     = sum[j][SHIFT +: COLNORM_WL];
`endif
    end
  end

  always_comb begin
    h_d        = h_q;
    row_d      = row_q;
    colnorm_d  = colnorm_q;
    colorder_d = colorder_q;
    for (int j = 0; j < 8; j++) acc_d[j] = acc_q[j];
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          h_d   = Hmatrix_i;
          row_d = 3'd0;
          for (int j = 0; j < 8; j++) acc_d[j] = '0;
        end
      end
      ACC: begin
        row_d = row_q + 3'd1;
        for (int j = 0; j < 8; j++) acc_d[j] = sum[j];
        if (row_q == 3'd7) begin
          for (int j = 0; j < 8; j++) begin
            colnorm_d[COLNORM_WL*j +: COLNORM_WL] = norm[j];
            colorder_d[3*j +: 3]                  = 3'(j);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q        <= '0;
      row_q      <= '0;
      colnorm_q  <= '0;
      colorder_q <= '0;
      for (int j = 0; j < 8; j++) acc_q[j] <= '0;
    end else begin
      h_q        <= h_d;
      row_q      <= row_d;
      colnorm_q  <= colnorm_d;
      colorder_q <= colorder_d;
      for (int j = 0; j < 8; j++) acc_q[j] <= acc_d[j];
    end
  end

  assign Hmatrix_o  = h_q;
  assign colnorm_o  = colnorm_q;
  assign colorder_o = colorder_q;

endmodule
